// File: rtl/fetch_controller.sv
// Instruction fetch controller: single outstanding fetch, branch redirect with
// in-flight discard, one-deep output hold, and a program-loader memory takeover.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        in_rst_n,
    input  logic        in_PCSrc,
    input  logic [31:0] in_branch_address,
    input  logic        in_stall,
    input  logic        in_mem_ack,
    input  logic [31:0] in_mem_rdata,
    output logic        out_mem_req,
    output logic        out_mem_we,
    output logic [31:0] out_mem_addr,
    output logic [31:0] out_mem_wdata,
    input  logic        in_load_req,
    input  logic        in_load_valid,
    input  logic [31:0] in_load_addr,
    input  logic [31:0] in_load_data,
    output logic        out_load_grant,
    output logic        out_load_ack,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus_four_out,
    output logic        out_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD,
        S_LOAD
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] branch_tgt;

    assign branch_tgt = in_branch_address & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            addr_q  <= PC_INIT;
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        addr_d         = addr_q;
        instr_d        = instr_q;
        pc4_d          = pc4_q;
        valid_d        = valid_q;
        out_mem_req    = 1'b0;
        out_mem_we     = 1'b0;
        out_mem_addr   = addr_q;
        out_mem_wdata  = 32'h0;
        out_load_grant = 1'b0;
        out_load_ack   = 1'b0;

        case (state_q)
            // Sole arbitration point; acks arriving here belong to no request.
            S_IDLE: begin
                if (in_load_req) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                end
            end
            S_FETCH: begin
                out_mem_req = 1'b1;
                if (in_mem_ack) begin
                    if (in_PCSrc) begin
                        pc_d    = branch_tgt;
                        state_d = S_IDLE;
                    end else begin
                        instr_d = in_mem_rdata;
                        pc4_d   = addr_q + 32'd4;
                        pc_d    = pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (in_PCSrc) begin
                    pc_d    = branch_tgt;
                    state_d = S_DISCARD;
                end
            end
            // Old request must still complete; its data is thrown away.
            S_DISCARD: begin
                out_mem_req = 1'b1;
                if (in_PCSrc) pc_d = branch_tgt;
                if (in_mem_ack) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (in_PCSrc || !in_stall) begin
                    if (in_PCSrc) pc_d = branch_tgt;
                    valid_d = 1'b0;
                    instr_d = NOP;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                out_load_grant = 1'b1;
                out_mem_req    = in_load_valid;
                out_mem_we     = 1'b1;
                out_mem_addr   = in_load_addr;
                out_mem_wdata  = in_load_data;
                out_load_ack   = in_mem_ack;
                if (!in_load_req && (!in_load_valid || in_mem_ack)) begin
                    pc_d    = PC_INIT;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instruction_out  = instr_q;
    assign pc_plus_four_out = pc4_q;
    assign out_valid        = valid_q;

endmodule
